// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the sequential slice adder.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned SliceWDefault    = 4;
    localparam int unsigned NumSlicesDefault = 4;

    // Chunk counter needs at least one bit even for a single slice.
    function automatic int unsigned cnt_width(input int unsigned num_slices);
        return (num_slices <= 1) ? 1 : $clog2(num_slices);
    endfunction

    localparam int unsigned CntWDefault = cnt_width(NumSlicesDefault);

endpackage

// File: rtl/adder_bit.sv
// Narrow combinational adder slice shared by the sequencer.
module adder_bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract sequenced through one narrow slice, LSB chunk first.
// Optional accumulator and acc_sel_i port are built when ADDER_SEQ_CTRL_ACC_EN is defined.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned SLICE_W    = SliceWDefault,
    parameter int unsigned NUM_SLICES = NumSlicesDefault
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef ADDER_SEQ_CTRL_ACC_EN
    input  logic                          acc_sel_i,
`endif
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          op_sub_i,
    input  logic [SLICE_W*NUM_SLICES-1:0] a_i,
    input  logic [SLICE_W*NUM_SLICES-1:0] b_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [SLICE_W*NUM_SLICES-1:0] sum_o,
    output logic                          cout_o,
    output logic                          ovf_o
);

    localparam int unsigned W    = SLICE_W * NUM_SLICES;
    localparam int unsigned CntW = cnt_width(NUM_SLICES);

    state_e            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      res_q;
    logic [W-1:0]      res_d;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic              a_msb_q;
    logic              b_msb_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              cout_q;
    logic              ovf_q;

    logic [W-1:0]       a_src;
    logic [W-1:0]       b_src;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_chunk;

`ifdef ADDER_SEQ_CTRL_ACC_EN
    logic [W-1:0] acc_q;

    assign a_src = acc_sel_i ? acc_q : a_i;
`else
    assign a_src = a_i;
`endif

    // Subtraction is a + ~b + 1; the +1 enters through the initial carry.
    assign b_src      = op_sub_i ? ~b_i : b_i;
    assign last_chunk = (cnt_q == CntW'(NUM_SLICES - 1));

    adder_bit #(
        .WIDTH (SLICE_W)
    ) u_slice (
        .a_i    (a_q[SLICE_W-1:0]),
        .b_i    (b_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Each slice result enters at the top so the first chunk ends up at bit 0.
    if (NUM_SLICES == 1) begin : g_res_one
        assign res_d = slice_sum;
    end else begin : g_res_multi
        assign res_d = {slice_sum, res_q[W-1:SLICE_W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ADDER_SEQ_CTRL_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_q        <= a_src;
                        b_q        <= b_src;
                        carry_q    <= op_sub_i;
                        cnt_q      <= '0;
                        a_msb_q    <= a_src[W-1];
                        b_msb_q    <= b_src[W-1];
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> SLICE_W;
                    b_q     <= b_q >> SLICE_W;
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (last_chunk) begin
                        cout_q      <= slice_cout;
                        ovf_q       <= (a_msb_q == b_msb_q) &&
                                       (slice_sum[SLICE_W-1] != a_msb_q);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
`ifdef ADDER_SEQ_CTRL_ACC_EN
                        acc_q       <= res_q;
`endif
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = res_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: randomized and directed ops against an arithmetic model.
module tb_adder_seq_ctrl;

    localparam int SW = 4;
    localparam int NS = 4;
    localparam int W  = SW * NS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         op_sub_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         acc_sel_i = 1'b0;

    adder_seq_ctrl #(
        .SLICE_W    (SW),
        .NUM_SLICES (NS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ADDER_SEQ_CTRL_ACC_EN
        .acc_sel_i   (acc_sel_i),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_sub_i    (op_sub_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] model_acc = '0;
    logic         hold_rdy = 1'b0;
    logic         rdy_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, overflow from the true signed result.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int   sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            r      = sa - sb;
        end else begin
            {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
            r               = sa + sb;
        end
        e.ovf     = (r > 32767) || (r < -32768);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic use_acc);
        int           waited = 0;
        exp_t         e;
        logic [W-1:0] a_eff;
        @(posedge clk); #1;
        a_i        = a;
        b_i        = b;
        op_sub_i   = sub;
        acc_sel_i  = use_acc;
        in_valid_i = 1'b1;
        while (!in_ready_o && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", waited);
            in_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        a_eff      = a;
`ifdef ADDER_SEQ_CTRL_ACC_EN
        if (use_acc) a_eff = model_acc;
`endif
        e         = model(a_eff, b, sub);
        e.acc_cyc = cyc;
        q.push_back(e);
        model_acc = e.sum;
        a_i       = W'($urandom);
        b_i       = W'($urandom);
        op_sub_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int waited = 0;
        while ((q.size() != 0 || out_valid_o) && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (q.size() != 0 || out_valid_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (hold_rdy) out_ready_i = 1'b0;
        else out_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid_o && !prev_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum 0x%0h, expected no output", sum_o);
                end else begin
                    check("latency", 32'(cyc - q[0].acc_cyc), 32'(NS));
                end
            end
            if (out_valid_o && prev_valid) begin
                check("sum_stable", 32'(sum_o), 32'(prev_sum));
                check("in_ready_done", 32'(in_ready_o), 32'd0);
            end
            if (out_valid_o && out_ready_i && q.size() != 0) begin
                mon_e = q.pop_front();
                check("sum", 32'(sum_o), 32'(mon_e.sum));
                check("cout", 32'(cout_o), 32'(mon_e.cout));
                check("ovf", 32'(ovf_o), 32'(mon_e.ovf));
            end
            prev_valid <= out_valid_o;
            prev_sum   <= sum_o;
        end
    end

    task automatic reset_outputs_check(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_sum"}, 32'(sum_o), 32'd0);
        check({tag, "_cout"}, 32'(cout_o), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_o), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        reset_outputs_check("reset");
        rst = 1'b0;

        issue(16'h0005, 16'h0001, 1'b0, 1'b0);
        issue(16'h0005, 16'h0001, 1'b1, 1'b0);
        issue(16'h0001, 16'h0005, 1'b1, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b0);
        drain();

        // Backpressure: hold out_ready low in DONE while poking in_valid.
        hold_rdy = 1'b1;
        issue(16'h1234, 16'h0101, 1'b0, 1'b0);
        waited = 0;
        while (!out_valid_o && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp_out_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            a_i        = W'($urandom);
            b_i        = W'($urandom);
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        hold_rdy   = 1'b0;
        drain();

        // Reset during the second RUN cycle discards the operation.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        reset_outputs_check("midrun_rst");
        q.delete();
        model_acc = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(16'h0003, 16'h0004, 1'b0, 1'b0);
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

`ifdef ADDER_SEQ_CTRL_ACC_EN
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        model_acc = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(W'($urandom), 16'h0010, 1'b0, 1'b1);
            drain();
            check("acc_sum", 32'(sum_o), 32'(16'h0010 * (i + 1)));
        end
        for (int i = 0; i < 10; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
